// File: rtl/lcd_vbuf_arbiter.sv
// Merges the two LCD pixel streams of a dual-core setup into one frame-buffer write port.
// Each source is queued in a small indexed FIFO; a round-robin arbiter drains them.
module lcd_vbuf_arbiter #(
  parameter int unsigned DW        = 15,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FRAME_PIX = 23040
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          clkena1_i,
  input  logic          clkena2_i,
  input  logic [DW-1:0] data1_i,
  input  logic [DW-1:0] data2_i,
  input  logic [1:0]    mode1_i,
  input  logic [1:0]    mode2_i,
  input  logic          on1_i,
  input  logic          on2_i,
  output logic          wr_en_o,
  output logic [15:0]   wr_addr_o,
  output logic [DW-1:0] wr_data_o,
  output logic          ovf1_o,
  output logic          ovf2_o,
  output logic          frame_done1_o,
  output logic          frame_done2_o
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW       = 15 + DW;
  localparam logic [14:0] FrameLen = 15'(FRAME_PIX);
  localparam logic [14:0] LastIdx  = 15'(FRAME_PIX - 1);
  localparam logic [AW:0] FullCnt  = (AW + 1)'(DEPTH);

  localparam logic [0:0] StLast1 = 1'b0;
  localparam logic [0:0] StLast2 = 1'b1;

  logic [1:0]      clkena, on, pop, nonempty, ovf;
  logic [3:0]      mode_all;
  logic [2*DW-1:0] data_all, head_data;
  logic [29:0]     head_idx;

  assign clkena   = {clkena2_i, clkena1_i};
  assign on       = {on2_i, on1_i};
  assign mode_all = {mode2_i, mode1_i};
  assign data_all = {data2_i, data1_i};

  for (genvar s = 0; s < 2; s++) begin : gen_src
    logic [14:0]   ptr_q, ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wp_q, rp_q;
    logic          ovf_q;
    logic [EW-1:0] mem_q [DEPTH];
    logic          restart, take, full, enq;

    // Restart (LCD off or vblank) rewinds the index and swallows the pixel.
    assign restart = !on[s] || (mode_all[2*s +: 2] == 2'b01);
    assign take    = clkena[s] && !restart && (ptr_q < FrameLen);
    assign full    = (count_q == FullCnt);
    assign enq     = take && (!full || pop[s]);

    always_comb begin
      ptr_d = ptr_q;
      if (restart) begin
        ptr_d = '0;
      end else if (take) begin
        ptr_d = ptr_q + 15'd1;
      end
      count_d = count_q;
      if (enq && !pop[s]) begin
        count_d = count_q + 1'b1;
      end else if (!enq && pop[s]) begin
        count_d = count_q - 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        ptr_q   <= '0;
        count_q <= '0;
        wp_q    <= '0;
        rp_q    <= '0;
        ovf_q   <= 1'b0;
      end else begin
        ptr_q   <= ptr_d;
        count_q <= count_d;
        if (enq)    wp_q <= wp_q + 1'b1;
        if (pop[s]) rp_q <= rp_q + 1'b1;
        if (take && full && !pop[s]) ovf_q <= 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (enq) mem_q[wp_q] <= {ptr_q, data_all[s*DW +: DW]};
    end

    assign nonempty[s]            = (count_q != '0);
    assign head_idx[15*s +: 15]   = mem_q[rp_q][EW-1 -: 15];
    assign head_data[DW*s +: DW]  = mem_q[rp_q][DW-1:0];
    assign ovf[s]                 = ovf_q;
  end

  logic [0:0] state_q, state_d;

  // On a tie the source not granted most recently wins.
  always_comb begin
    pop     = 2'b00;
    state_d = state_q;
    if (nonempty[0] && nonempty[1]) begin
      if (state_q == StLast2) begin
        pop[0]  = 1'b1;
        state_d = StLast1;
      end else begin
        pop[1]  = 1'b1;
        state_d = StLast2;
      end
    end else if (nonempty[0]) begin
      pop[0]  = 1'b1;
      state_d = StLast1;
    end else if (nonempty[1]) begin
      pop[1]  = 1'b1;
      state_d = StLast2;
    end
  end

  logic          wr_en_q, fd1_q, fd2_q;
  logic [15:0]   wr_addr_q;
  logic [DW-1:0] wr_data_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StLast2;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      fd1_q     <= 1'b0;
      fd2_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= |pop;
      fd1_q   <= pop[0] && (head_idx[14:0] == LastIdx);
      fd2_q   <= pop[1] && (head_idx[29:15] == LastIdx);
      if (pop[0]) begin
        wr_addr_q <= {1'b0, head_idx[14:0]};
        wr_data_q <= head_data[DW-1:0];
      end else if (pop[1]) begin
        wr_addr_q <= {1'b1, head_idx[29:15]};
        wr_data_q <= head_data[2*DW-1:DW];
      end
    end
  end

  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign ovf1_o        = ovf[0];
  assign ovf2_o        = ovf[1];
  assign frame_done1_o = fd1_q;
  assign frame_done2_o = fd2_q;

endmodule

// File: tb/tb_lcd_vbuf_arbiter.sv
// Directed self-checking bench for lcd_vbuf_arbiter (DW=15, DEPTH=4, FRAME_PIX=23040).
module tb_lcd_vbuf_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clkena1, clkena2, on1, on2;
  logic [14:0] data1, data2;
  logic [1:0]  mode1, mode2;
  logic        wr_en, ovf1, ovf2, fd1, fd2;
  logic [15:0] wr_addr;
  logic [14:0] wr_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] log_addr [$];
  logic [14:0] log_data [$];
  int          fd1_cnt, fd2_cnt;
  logic [15:0] fd1_addr;

  lcd_vbuf_arbiter dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .clkena1_i    (clkena1),
    .clkena2_i    (clkena2),
    .data1_i      (data1),
    .data2_i      (data2),
    .mode1_i      (mode1),
    .mode2_i      (mode2),
    .on1_i        (on1),
    .on2_i        (on2),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .ovf1_o       (ovf1),
    .ovf2_o       (ovf2),
    .frame_done1_o(fd1),
    .frame_done2_o(fd2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
    if (fd1 === 1'b1) begin
      fd1_cnt++;
      fd1_addr = wr_addr;
    end
    if (fd2 === 1'b1) fd2_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    fd1_cnt = 0;
    fd2_cnt = 0;
    fd1_addr = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clkena1 = 0; clkena2 = 0; data1 = '0; data2 = '0;
    on1 = 1; on2 = 1; mode1 = 2'b11; mode2 = 2'b11;
    repeat (2) step();
    reset_n = 1'b1;
    clear_log();
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clkena1 = 0; clkena2 = 0; data1 = '0; data2 = '0;
    on1 = 0; on2 = 0; mode1 = 2'b00; mode2 = 2'b00;
    #2;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    checks++; if (wr_addr !== 16'h0) begin errors++; $display("FAIL reset_wr_addr got %h want 0000", wr_addr); end
    checks++; if (wr_data !== 15'h0) begin errors++; $display("FAIL reset_wr_data got %h want 0000", wr_data); end
    checks++; if ({ovf1, ovf2} !== 2'b00) begin errors++; $display("FAIL reset_ovf got %b want 00", {ovf1, ovf2}); end
    checks++; if ({fd1, fd2} !== 2'b00) begin errors++; $display("FAIL reset_frame_done got %b want 00", {fd1, fd2}); end
  endtask

  task automatic test_single();
    do_reset();
    on2 = 0;
    for (int i = 0; i < 5; i++) begin
      clkena1 = 1; data1 = 15'(i);
      step();
      clkena1 = 0;
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL single_no_bypass[%0d] got %b want 0", i, wr_en); end
      step();
      checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en[%0d] got %b want 1", i, wr_en); end
      checks++; if (wr_addr !== 16'(i)) begin errors++; $display("FAIL single_addr[%0d] got %h want %h", i, wr_addr, 16'(i)); end
      checks++; if (wr_data !== 15'(i)) begin errors++; $display("FAIL single_data[%0d] got %h want %h", i, wr_data, 15'(i)); end
    end
  endtask

  task automatic test_contention();
    do_reset();
    clkena1 = 1; clkena2 = 1; data1 = 15'h1111; data2 = 15'h2222;
    step();
    clkena1 = 0; clkena2 = 0;
    step();
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'h0000, 15'h1111}) begin
      errors++; $display("FAIL contention_first got %b %h %h want 1 0000 1111", wr_en, wr_addr, wr_data); end
    step();
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'h8000, 15'h2222}) begin
      errors++; $display("FAIL contention_second got %b %h %h want 1 8000 2222", wr_en, wr_addr, wr_data); end
    step();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL contention_idle got %b want 0", wr_en); end
    clkena1 = 1; clkena2 = 1; data1 = 15'h0aaa; data2 = 15'h0bbb;
    step();
    clkena1 = 0; clkena2 = 0;
    step();
    checks++; if ({wr_addr, wr_data} !== {16'h0001, 15'h0aaa}) begin
      errors++; $display("FAIL contention_tie2_first got %h %h want 0001 0aaa", wr_addr, wr_data); end
    step();
    checks++; if ({wr_addr, wr_data} !== {16'h8001, 15'h0bbb}) begin
      errors++; $display("FAIL contention_tie2_second got %h %h want 8001 0bbb", wr_addr, wr_data); end
  endtask

  task automatic test_overflow();
    int n1, n2, n2_idx7;
    do_reset();
    // Eight dual pushes: core 2's eighth pixel (idx 7) is the first drop.
    for (int i = 0; i < 8; i++) begin
      clkena1 = 1; clkena2 = 1;
      data1 = 15'h100 + 15'(i); data2 = 15'h200 + 15'(i);
      step();
      if (i == 6) begin
        checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", ovf2); end
      end
    end
    clkena1 = 0; clkena2 = 0;
    checks++; if (ovf2 !== 1'b1) begin errors++; $display("FAIL ovf2_set got %b want 1", ovf2); end
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL ovf1_clear got %b want 0", ovf1); end
    repeat (12) step();
    clkena2 = 1; data2 = 15'h208;
    step();
    clkena2 = 0;
    repeat (3) step();
    n1 = 0; n2 = 0; n2_idx7 = 0;
    foreach (log_addr[k]) begin
      if (log_addr[k][15]) begin
        n2++;
        if (log_addr[k][14:0] == 15'd7) n2_idx7++;
      end else begin
        n1++;
      end
      checks++;
      if (log_data[k] !== ((log_addr[k][15] ? 15'h200 : 15'h100) + log_addr[k][14:0])) begin
        errors++; $display("FAIL ovf_data[%0d] addr %h got %h", k, log_addr[k], log_data[k]); end
    end
    checks++; if (n1 != 8) begin errors++; $display("FAIL ovf_core1_writes got %0d want 8", n1); end
    checks++; if (n2 != 8) begin errors++; $display("FAIL ovf_core2_writes got %0d want 8", n2); end
    checks++; if (n2_idx7 != 0) begin errors++; $display("FAIL ovf_gap got %0d writes of idx7 want 0", n2_idx7); end
    checks++; if (log_addr.size() == 0 || log_addr[log_addr.size()-1] !== 16'h8008) begin
      errors++; $display("FAIL ovf_after_gap got %h want 8008",
                         log_addr.size() == 0 ? 16'hxxxx : log_addr[log_addr.size()-1]); end
    checks++; if ({ovf1, ovf2} !== 2'b01) begin errors++; $display("FAIL ovf_sticky got %b want 01", {ovf1, ovf2}); end
  endtask

  task automatic test_restart();
    int sz;
    do_reset();
    for (int k = 0; k < 98; k++) begin
      clkena1 = 1; data1 = 15'(k);
      step();
      clkena1 = 0;
      step();
    end
    // Core 2 steals a slot so FIFO1 holds idx 98 and 99 when restart arrives.
    clkena1 = 1; data1 = 15'd98; clkena2 = 1; data2 = 15'h5555;
    step();
    clkena2 = 0; data1 = 15'd99;
    step();
    mode1 = 2'b01; data1 = 15'h7777;
    repeat (3) step();
    mode1 = 2'b11; clkena1 = 0;
    step();
    clkena1 = 1; data1 = 15'h0abc;
    step();
    clkena1 = 0;
    repeat (3) step();
    sz = log_addr.size();
    checks++; if (sz != 102) begin errors++; $display("FAIL restart_count got %0d want 102", sz); end
    if (sz >= 3) begin
      checks++; if ({log_addr[sz-3], log_data[sz-3]} !== {16'd98, 15'd98}) begin
        errors++; $display("FAIL restart_idx98 got %h %h want 0062 0062", log_addr[sz-3], log_data[sz-3]); end
      checks++; if ({log_addr[sz-2], log_data[sz-2]} !== {16'd99, 15'd99}) begin
        errors++; $display("FAIL restart_idx99 got %h %h want 0063 0063", log_addr[sz-2], log_data[sz-2]); end
      checks++; if ({log_addr[sz-1], log_data[sz-1]} !== {16'h0000, 15'h0abc}) begin
        errors++; $display("FAIL restart_idx0 got %h %h want 0000 0abc", log_addr[sz-1], log_data[sz-1]); end
    end else begin
      checks++; errors++; $display("FAIL restart_tail got %0d writes want 102", sz);
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    on2 = 0;
    for (int k = 0; k < 23041; k++) begin
      clkena1 = 1; data1 = 15'(k);
      step();
    end
    clkena1 = 0;
    repeat (4) step();
    checks++; if (fd1_cnt != 1) begin errors++; $display("FAIL frame_done1_count got %0d want 1", fd1_cnt); end
    checks++; if (fd1_addr !== 16'h59ff) begin errors++; $display("FAIL frame_done1_addr got %h want 59ff", fd1_addr); end
    checks++; if (fd2_cnt != 0) begin errors++; $display("FAIL frame_done2_count got %0d want 0", fd2_cnt); end
    checks++; if (log_addr.size() != 23040) begin
      errors++; $display("FAIL frame_writes got %0d want 23040", log_addr.size()); end
    checks++; if (log_addr.size() == 0 || log_addr[log_addr.size()-1] !== 16'h59ff) begin
      errors++; $display("FAIL frame_last_addr got %h want 59ff",
                         log_addr.size() == 0 ? 16'hxxxx : log_addr[log_addr.size()-1]); end
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL frame_ovf1 got %b want 0", ovf1); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clkena1 = 1; clkena2 = 1; data1 = 15'h300 + 15'(i); data2 = 15'h400 + 15'(i);
      step();
    end
    clkena1 = 0; clkena2 = 0;
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL async_pre_wr_en got %b want 1", wr_en); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b0, 16'h0, 15'h0}) begin
      errors++; $display("FAIL async_clear got %b %h %h want 0 0000 0000", wr_en, wr_addr, wr_data); end
    checks++; if ({ovf1, ovf2, fd1, fd2} !== 4'b0) begin
      errors++; $display("FAIL async_flags got %b want 0000", {ovf1, ovf2, fd1, fd2}); end
    step();
    reset_n = 1'b1;
    clear_log();
    step();
    clkena1 = 1; data1 = 15'h0123;
    step();
    clkena1 = 0;
    repeat (4) step();
    checks++; if (log_addr.size() != 1) begin
      errors++; $display("FAIL async_post_count got %0d want 1", log_addr.size()); end
    else begin
      checks++; if ({log_addr[0], log_data[0]} !== {16'h0000, 15'h0123}) begin
        errors++; $display("FAIL async_post_write got %h %h want 0000 0123", log_addr[0], log_data[0]); end
    end
  endtask

  initial begin
    fd1_cnt = 0; fd2_cnt = 0; fd1_addr = '0;
    test_reset();
    test_single();
    test_contention();
    test_overflow();
    test_restart();
    test_full_frame();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
